// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic: field constants, Barrett parameters and the small
// modular helpers used by the processing elements.
package ntt_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int Q          = 3329;
  localparam int MUL_LAT    = 3;
  localparam int BARRETT_K  = 24;
  localparam int BARRETT_M  = 5039;  // floor(2^24 / Q)
  localparam int BM_WIDTH   = 13;

  typedef logic [DATA_WIDTH-1:0]            coef_t;
  typedef logic [DATA_WIDTH:0]              coef_ext_t;
  typedef logic [2*DATA_WIDTH-1:0]          prod_t;
  typedef logic [2*DATA_WIDTH+BM_WIDTH-1:0] bprod_t;

  localparam coef_ext_t Q_EXT  = coef_ext_t'(Q);
  localparam prod_t     Q_PROD = prod_t'(Q);

  function automatic coef_t add_mod(input coef_t a, input coef_t b);
    coef_ext_t s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_EXT) s = s - Q_EXT;
    return coef_t'(s);
  endfunction

  function automatic coef_t sub_mod(input coef_t a, input coef_t b);
    coef_ext_t d;
    if (a < b) d = {1'b0, a} + Q_EXT - {1'b0, b};
    else       d = {1'b0, a} - {1'b0, b};
    return coef_t'(d);
  endfunction

  // Division by 2 in the field: odd values borrow one Q to become even.
  function automatic coef_t halve_mod(input coef_t x, input logic en);
    if (!en) return x;
    if (!x[0]) return x >> 1;
    return coef_t'(({1'b0, x} + Q_EXT) >> 1);
  endfunction

  // x < Q^2 < 2^24, so the quotient estimate is short by at most one and a
  // single conditional subtract suffices.
  function automatic coef_t barrett_reduce(input prod_t x);
    bprod_t t;
    prod_t  q_est;
    prod_t  r;
    t     = bprod_t'(x) * bprod_t'(BARRETT_M);
    q_est = prod_t'(t >> BARRETT_K);
    r     = x - prod_t'(q_est * Q_PROD);
    if (r >= Q_PROD) r = r - Q_PROD;
    return coef_t'(r);
  endfunction
endpackage

// File: rtl/pe2_intt_bf_if.sv
// Butterfly stream bundle. Valid-only: in_valid qualifies u/v/w/half_en for one
// cycle and is always accepted; out_valid qualifies the results for one cycle.
interface pe2_intt_bf_if;
  import ntt_pkg::*;
  logic  in_valid;
  coef_t u;
  coef_t v;
  coef_t w;
  logic  half_en;
  logic  out_valid;
  coef_t bf_upper;
  coef_t bf_lower;
  logic  busy;

  modport master (output in_valid, u, v, w, half_en,
                  input  out_valid, bf_upper, bf_lower, busy);
  modport slave  (input  in_valid, u, v, w, half_en,
                  output out_valid, bf_upper, bf_lower, busy);
endinterface

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier: p = a*b mod Q, LAT register stages, Barrett
// reduction after the product register.
module mod_mul_pipe
  import ntt_pkg::*;
#(
  parameter int LAT = MUL_LAT
) (
  input  logic  clk,
  input  logic  rst,
  input  coef_t a,
  input  coef_t b,
  output coef_t p
);
  prod_t r_prod;
  coef_t w_red;

  always_ff @(posedge clk) begin
    if (rst) r_prod <= '0;
    else     r_prod <= prod_t'(a) * prod_t'(b);
  end

  assign w_red = barrett_reduce(r_prod);

  if (LAT == 1) begin : g_lat1
    assign p = w_red;
  end else begin : g_latn
    logic [LAT-2:0][DATA_WIDTH-1:0] r_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= w_red;
        for (int i = 1; i < LAT - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign p = r_pipe[LAT-2];
  end
endmodule

// File: rtl/pe2_intt_bf.sv
// Gentleman-Sande inverse butterfly: upper=(u+v)[/2], lower=((u-v)*w)[/2] mod Q.
// Fixed latency P_MUL_LAT+3, one token per cycle, no backpressure.
module pe2_intt_bf
  import ntt_pkg::*;
#(
  parameter int P_MUL_LAT = MUL_LAT
) (
  input logic          clk,
  input logic          rst,
  pe2_intt_bf_if.slave bf_if
);
  logic  r_s0_vld;
  coef_t r_s0_u;
  coef_t r_s0_v;
  coef_t r_s0_w;
  logic  r_s0_half;

  logic  r_s1_vld;
  coef_t r_s1_sum;
  coef_t r_s1_diff;
  coef_t r_s1_w;
  logic  r_s1_half;

  // Sum/half/valid ride alongside the multiplier so both paths stay aligned.
  logic [P_MUL_LAT-1:0][DATA_WIDTH-1:0] r_sum_dly;
  logic [P_MUL_LAT-1:0]                 r_half_dly;
  logic [P_MUL_LAT-1:0]                 r_vld_dly;

  logic  r_out_vld;
  coef_t r_out_upper;
  coef_t r_out_lower;
  coef_t w_mul_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_vld    <= 1'b0;
      r_s0_u      <= '0;
      r_s0_v      <= '0;
      r_s0_w      <= '0;
      r_s0_half   <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_diff   <= '0;
      r_s1_w      <= '0;
      r_s1_half   <= 1'b0;
      r_sum_dly   <= '0;
      r_half_dly  <= '0;
      r_vld_dly   <= '0;
      r_out_vld   <= 1'b0;
      r_out_upper <= '0;
      r_out_lower <= '0;
    end else begin
      r_s0_vld  <= bf_if.in_valid;
      r_s0_u    <= bf_if.u;
      r_s0_v    <= bf_if.v;
      r_s0_w    <= bf_if.w;
      r_s0_half <= bf_if.half_en;

      r_s1_vld  <= r_s0_vld;
      r_s1_sum  <= add_mod(r_s0_u, r_s0_v);
      r_s1_diff <= sub_mod(r_s0_u, r_s0_v);
      r_s1_w    <= r_s0_w;
      r_s1_half <= r_s0_half;

      r_sum_dly[0]  <= r_s1_sum;
      r_half_dly[0] <= r_s1_half;
      r_vld_dly[0]  <= r_s1_vld;
      for (int i = 1; i < P_MUL_LAT; i++) begin
        r_sum_dly[i]  <= r_sum_dly[i-1];
        r_half_dly[i] <= r_half_dly[i-1];
        r_vld_dly[i]  <= r_vld_dly[i-1];
      end

      r_out_vld   <= r_vld_dly[P_MUL_LAT-1];
      r_out_upper <= halve_mod(r_sum_dly[P_MUL_LAT-1], r_half_dly[P_MUL_LAT-1]);
      r_out_lower <= halve_mod(w_mul_p, r_half_dly[P_MUL_LAT-1]);
    end
  end

  mod_mul_pipe #(
    .LAT (P_MUL_LAT)
  ) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (r_s1_diff),
    .b   (r_s1_w),
    .p   (w_mul_p)
  );

  assign bf_if.out_valid = r_out_vld;
  assign bf_if.bf_upper  = r_out_upper;
  assign bf_if.bf_lower  = r_out_lower;
  assign bf_if.busy      = r_s0_vld | r_s1_vld | (|r_vld_dly) | r_out_vld;
endmodule

// File: tb/tb_pe2_intt_bf.sv
// Bench for pe2_intt_bf: directed and random tokens, scoreboard keyed on the
// cycle each result is due, so latency and bubble positions are checked too.
module tb_pe2_intt_bf;
  localparam int QV  = ntt_pkg::Q;
  localparam int LAT = ntt_pkg::MUL_LAT + 3;
  localparam int EW  = 56;  // {due_cycle[31:0], upper[11:0], lower[11:0]}

  logic clk;
  logic rst;
  int   cyc;
  int   n_assert;
  int   n_fail;
  logic [EW-1:0] exp_q[$];

  pe2_intt_bf_if bf ();

  pe2_intt_bf dut (
    .clk   (clk),
    .rst   (rst),
    .bf_if (bf.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [23:0] model(input int uu, input int vv, input int ww, input bit hh);
    int s;
    int d;
    s = (uu + vv) % QV;
    d = (((uu - vv + QV) % QV) * ww) % QV;
    if (hh) begin
      s = (s % 2 == 1) ? (s + QV) / 2 : s / 2;
      d = (d % 2 == 1) ? (d + QV) / 2 : d / 2;
    end
    return {12'(s), 12'(d)};
  endfunction

  // driver tasks: called at a negedge, return at the next negedge
  task automatic drive_tok(input int uu, input int vv, input int ww, input bit hh,
                           input logic [23:0] expv);
    bf.in_valid = 1'b1;
    bf.u        = 12'(uu);
    bf.v        = 12'(vv);
    bf.w        = 12'(ww);
    bf.half_en  = hh;
    exp_q.push_back({32'(cyc + LAT), expv});
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bf.in_valid = 1'b0;
    bf.u        = 12'($urandom_range(0, QV - 1));
    bf.v        = 12'($urandom_range(0, QV - 1));
    bf.w        = 12'($urandom_range(0, QV - 1));
    bf.half_en  = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) @(negedge clk);
    n_assert++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: %0d results still outstanding, expected 0", tag, exp_q.size());
    end
    n_assert++;
    assert (bf.busy === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_busy_idle: busy=%b expected 0", tag, bf.busy);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() != 0 && int'(exp_q[0][55:24]) == cyc) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (bf.out_valid === 1'b1 && {bf.bf_upper, bf.bf_lower} === e[23:0]) else begin
        n_fail++;
        $error("FAIL result@%0d: valid=%b upper=%0d lower=%0d expected valid=1 upper=%0d lower=%0d",
               cyc, bf.out_valid, bf.bf_upper, bf.bf_lower, e[23:12], e[11:0]);
      end
    end else if (rst === 1'b0) begin
      n_assert++;
      assert (bf.out_valid === 1'b0) else begin
        n_fail++;
        $error("FAIL unexpected_valid@%0d: out_valid=%b expected 0", cyc, bf.out_valid);
      end
    end
  end

  initial begin
    int sent;
    int slot;
    int ru;
    int rv;
    int rw;
    bit rh;
    n_assert    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bf.in_valid = 1'b0;
    bf.u        = '0;
    bf.v        = '0;
    bf.w        = '0;
    bf.half_en  = 1'b0;

    repeat (2) @(negedge clk);
    n_assert++;
    assert ({bf.out_valid, bf.busy, bf.bf_upper, bf.bf_lower} === 26'd0) else begin
      n_fail++;
      $error("FAIL reset_state: valid=%b busy=%b upper=%0d lower=%0d expected all 0",
             bf.out_valid, bf.busy, bf.bf_upper, bf.bf_lower);
    end
    rst = 1'b0;
    drive_idle();

    // directed tokens with hand-computed results
    drive_tok(10, 4, 1, 1'b1, {12'd7, 12'd3});
    n_assert++;
    assert (bf.busy === 1'b1) else begin
      n_fail++;
      $error("FAIL busy_inflight: busy=%b expected 1", bf.busy);
    end
    drive_idle();
    drive_tok(3, 4, 1, 1'b1, {12'd1668, 12'd1664});
    drive_tok(5, 2, 17, 1'b1, {12'd1668, 12'd1690});
    drive_tok(5, 2, 17, 1'b0, {12'd7, 12'd51});
    drive_tok(100, 100, 55, 1'b1, {12'd100, 12'd0});
    drive_tok(QV - 1, QV - 1, 1, 1'b0, {12'd3327, 12'd0});
    drive_tok(0, QV - 1, 1, 1'b0, {12'd3328, 12'd1});
    drive_tok(QV - 1, 0, 1, 1'b1, {12'd1664, 12'd1664});
    drive_tok(3, 4, 1, 1'b0, {12'd7, 12'd3328});
    drive_tok(3, 4, 1, 1'b1, {12'd1668, 12'd1664});
    drive_idle();
    drain("directed");

    // random stream, bubble every 7th slot
    sent = 0;
    slot = 0;
    while (sent < 200) begin
      if (slot % 7 == 6) begin
        drive_idle();
      end else begin
        ru = $urandom_range(0, QV - 1);
        rv = $urandom_range(0, QV - 1);
        rw = $urandom_range(0, QV - 1);
        rh = 1'($urandom_range(0, 1));
        drive_tok(ru, rv, rw, rh, model(ru, rv, rw, rh));
        sent++;
      end
      slot++;
    end
    drive_idle();
    drain("stream");

    // reset with four tokens in flight
    for (int i = 0; i < 4; i++) begin
      ru = $urandom_range(0, QV - 1);
      rv = $urandom_range(0, QV - 1);
      rw = $urandom_range(0, QV - 1);
      drive_tok(ru, rv, rw, 1'b1, model(ru, rv, rw, 1'b1));
    end
    bf.in_valid = 1'b0;
    rst         = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_assert++;
    assert ({bf.busy, bf.out_valid} === 2'b00) else begin
      n_fail++;
      $error("FAIL midreset_flush: busy=%b valid=%b expected 0 0", bf.busy, bf.out_valid);
    end
    rst = 1'b0;
    repeat (2 * LAT) drive_idle();
    ru = $urandom_range(0, QV - 1);
    rv = $urandom_range(0, QV - 1);
    rw = $urandom_range(0, QV - 1);
    drive_tok(ru, rv, rw, 1'b1, model(ru, rv, rw, 1'b1));
    drive_idle();
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
